// File: rtl/dsp_addr_decoder_param_if.sv
// DSP XZCS0/1 external bus: active-low chip select plus address.
interface dsp_addr_decoder_param_if #(
  parameter int ADDR_W = 19
);
  logic              xzcs0and1;
  logic [ADDR_W-1:0] dsp_address;

  modport master (output xzcs0and1, dsp_address);
  modport slave  (input  xzcs0and1, dsp_address);
endinterface

// File: rtl/dsp_addr_decoder_param.sv
// DSP bus address decoder: sticky set/clear bits, level strobes, fixed-length pulse generators.
// Optional sticky unmapped-access flag built only when ADDR_ERR_EN is defined.
module dsp_pulse_gen #(
  parameter int PULSE_LEN = 256,
  parameter int CNT_W     = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic pulse_o
);
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Triggers are only honoured from IDLE, so a running pulse is never stretched.
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end else if (trig_i) begin
      run_d = 1'b1;
      cnt_d = CNT_W'(PULSE_LEN - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = run_q;
endmodule

module dsp_addr_decoder_param #(
  parameter int                ADDR_W    = 19,
  parameter logic [ADDR_W-1:0] CTRL_BASE = 19'h04000,
  parameter logic [ADDR_W-1:0] STRB_BASE = 19'h02000,
  parameter int                N_CTRL    = 16,
  parameter int                N_STRB    = 8,
  parameter int                N_PULSE   = 4,
  parameter int                PULSE_LEN = 256,
  parameter logic [N_CTRL-1:0] CTRL_RST  = 16'h0003
) (
  input  logic                dsp_clkout,
  input  logic                reset,
  dsp_addr_decoder_param_if.slave bus,
  output logic [N_CTRL-1:0]   ctrl_out,
  output logic [N_STRB-1:0]   strb_out,
  output logic [N_PULSE-1:0]  pulse_out,
  output logic [N_PULSE-1:0]  pulse_busy,
  output logic                addr_err
);
  localparam int CNT_W   = $clog2(PULSE_LEN);
  localparam int ERR_OFF = 2*N_CTRL + N_PULSE;
  localparam int CB      = int'(CTRL_BASE);
  localparam int SB      = int'(STRB_BASE);

  if ((CB < SB + N_STRB) && (SB < CB + ERR_OFF + 1)) begin : g_overlap
    $error("dsp_addr_decoder_param: control and strobe windows overlap");
  end

  logic              cs_q;
  logic [N_CTRL-1:0] ctrl_q, ctrl_d;
  logic [N_STRB-1:0] strb_q, strb_d;
  logic [N_PULSE-1:0] trig;
  logic [N_CTRL-1:0] ctrl_set, ctrl_clr;
  logic [N_PULSE-1:0] trig_hit;
  logic [ADDR_W-1:0] addr, c_off, s_off;
  logic              access, first, in_c, in_s;

  assign addr   = bus.dsp_address;
  assign access = ~bus.xzcs0and1;
  assign first  = access & cs_q;
  assign c_off  = addr - CTRL_BASE;
  assign s_off  = addr - STRB_BASE;
  assign in_c   = access && (addr >= CTRL_BASE) && (c_off < ADDR_W'(64));
  assign in_s   = access && (addr >= STRB_BASE) && (s_off < ADDR_W'(32));

  always_comb begin
    ctrl_set = '0;
    ctrl_clr = '0;
    strb_d   = '0;
    trig_hit = '0;
    for (int i = 0; i < N_CTRL; i++) begin
      ctrl_set[i] = in_c && (c_off == ADDR_W'(2*i));
      ctrl_clr[i] = in_c && (c_off == ADDR_W'(2*i + 1));
    end
    for (int k = 0; k < N_STRB; k++)
      strb_d[k] = in_s && (s_off == ADDR_W'(k));
    for (int j = 0; j < N_PULSE; j++)
      trig_hit[j] = in_c && (c_off == ADDR_W'(2*N_CTRL + j));
  end

  assign ctrl_d = (ctrl_q | ctrl_set) & ~ctrl_clr;
  assign trig   = trig_hit & {N_PULSE{first}};

  always_ff @(posedge dsp_clkout) begin
    if (!reset) begin
      cs_q   <= 1'b1;
      ctrl_q <= CTRL_RST;
      strb_q <= '0;
    end else begin
      cs_q   <= bus.xzcs0and1;
      ctrl_q <= ctrl_d;
      strb_q <= strb_d;
    end
  end

  for (genvar j = 0; j < N_PULSE; j++) begin : g_pulse
    dsp_pulse_gen #(.PULSE_LEN(PULSE_LEN), .CNT_W(CNT_W)) u_pg (
      .clk_i  (dsp_clkout),
      .rst_ni (reset),
      .trig_i (trig[j]),
      .pulse_o(pulse_out[j])
    );
  end

`ifdef ADDR_ERR_EN
  logic err_q, err_d, err_set, err_clr, mapped;

  assign mapped  = |{ctrl_set, ctrl_clr, strb_d, trig_hit};
  assign err_clr = in_c && (c_off == ADDR_W'(ERR_OFF));
  assign err_set = first && (in_c || in_s) && !mapped && !err_clr;

  always_comb begin
    err_d = err_q;
    if (err_clr)      err_d = 1'b0;
    else if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge dsp_clkout) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign addr_err = err_q;
`else
  assign addr_err = 1'b0;
`endif

  assign ctrl_out   = ctrl_q;
  assign strb_out   = strb_q;
  assign pulse_busy = pulse_out;
endmodule

// File: tb/tb_dsp_addr_decoder_param.sv
// Directed bench for dsp_addr_decoder_param with hand-computed expectations.
module tb_dsp_addr_decoder_param;
  localparam logic [18:0] CB = 19'h04000;
  localparam logic [18:0] SB = 19'h02000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ctrl_out;
  logic [7:0]  strb_out;
  logic [3:0]  pulse_out, pulse_busy;
  logic        addr_err;
  int          nvec = 0;
  int          nerr = 0;
  int          width;

  always #5 clk = ~clk;

  dsp_addr_decoder_param_if #(.ADDR_W(19)) bus_if ();

  dsp_addr_decoder_param dut (
    .dsp_clkout(clk),
    .reset     (rst_n),
    .bus       (bus_if),
    .ctrl_out  (ctrl_out),
    .strb_out  (strb_out),
    .pulse_out (pulse_out),
    .pulse_busy(pulse_busy),
    .addr_err  (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic [18:0] a);
    bus_if.xzcs0and1   = cs;
    bus_if.dsp_address = a;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, '0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ctrl",  32'(ctrl_out),   32'h0003);
    chk("rst_strb",  32'(strb_out),   32'h0);
    chk("rst_pulse", 32'(pulse_out),  32'h0);
    chk("rst_busy",  32'(pulse_busy), 32'h0);
    chk("rst_err",   32'(addr_err),   32'h0);

    // set bit 2 then clear bit 0
    drive(1'b0, CB + 19'd4); tick();
    chk("ctrl_set2", 32'(ctrl_out), 32'h0007);
    drive(1'b0, CB + 19'd1); tick();
    chk("ctrl_clr0", 32'(ctrl_out), 32'h0006);
    drive(1'b1, CB + 19'd1); tick();
    chk("ctrl_hold", 32'(ctrl_out), 32'h0006);

    // strobe 3 held 5 cycles
    drive(1'b0, SB + 19'd3);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("strb3_on", 32'(strb_out), 32'h08);
    end
    drive(1'b1, SB + 19'd3); tick();
    chk("strb3_off", 32'(strb_out), 32'h00);
    drive(1'b0, SB + 19'd5); tick();
    chk("strb5_on", 32'(strb_out), 32'h20);
    drive(1'b0, 19'h07000); tick();
    chk("strb_unmap", 32'(strb_out), 32'h00);
    chk("ctrl_unmap", 32'(ctrl_out), 32'h0006);
    drive(1'b1, '0); tick();

    // pulse 0 with retrigger at cycle 100
    drive(1'b0, CB + 19'd32); tick();
    chk("p0_start", 32'(pulse_out), 32'h1);
    chk("p0_busy",  32'(pulse_busy), 32'h1);
    width = 1;
    for (int n = 0; n < 400 && pulse_out[0]; n++) begin
      if (width == 100) drive(1'b0, CB + 19'd32);
      else              drive(1'b1, CB + 19'd32);
      tick();
      if (pulse_out[0]) width++;
    end
    chk("p0_width_retrig", 32'(width), 32'd256);
    chk("p0_end", 32'(pulse_out), 32'h0);

    // trigger 1 cycle after end; trigger at the cnt=0 cycle is ignored
    drive(1'b0, CB + 19'd32); tick();
    chk("p0_restart", 32'(pulse_out), 32'h1);
    drive(1'b1, CB + 19'd32);
    width = 1;
    for (int n = 0; n < 400 && pulse_out[0]; n++) begin
      if (width == 256) drive(1'b0, CB + 19'd32);
      else              drive(1'b1, CB + 19'd32);
      tick();
      if (pulse_out[0]) width++;
    end
    chk("p0_width2", 32'(width), 32'd256);
    drive(1'b1, CB + 19'd32); tick();
    chk("p0_last_trig_ignored", 32'(pulse_out), 32'h0);

    // CS held low for 300 cycles on trigger 1: one pulse only
    drive(1'b0, CB + 19'd33);
    width = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (pulse_out[1]) width++;
    end
    chk("p1_hold_width", 32'(width), 32'd256);
    chk("p1_hold_end", 32'(pulse_out), 32'h0);
    drive(1'b1, '0); tick();

    // reset mid-pulse
    drive(1'b0, CB + 19'd34); tick();
    drive(1'b1, '0);
    for (int n = 0; n < 49; n++) tick();
    chk("p2_running", 32'(pulse_out), 32'h4);
    rst_n = 1'b0; tick();
    chk("rst_mid_pulse", 32'(pulse_out), 32'h0);
    chk("rst_mid_ctrl",  32'(ctrl_out),  32'h0003);
    rst_n = 1'b1; tick();
    chk("rst_mid_after", 32'(pulse_out), 32'h0);

    // unmapped-in-window flag
    drive(1'b0, CB + 19'd60); tick();
`ifdef ADDR_ERR_EN
    chk("err_set_ctrl", 32'(addr_err), 32'h1);
`else
    chk("err_off_ctrl", 32'(addr_err), 32'h0);
`endif
    drive(1'b1, '0); tick();
    drive(1'b0, CB + 19'd36); tick();
    chk("err_clr", 32'(addr_err), 32'h0);
    drive(1'b1, '0); tick();
    drive(1'b0, SB + 19'd20); tick();
`ifdef ADDR_ERR_EN
    chk("err_set_strb", 32'(addr_err), 32'h1);
`else
    chk("err_off_strb", 32'(addr_err), 32'h0);
`endif
    chk("strb_unmapped", 32'(strb_out), 32'h00);
    drive(1'b1, '0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
